hilo_pipe: RTL
==============

# hilo_pipe

HI/LO register pair with its own write-back pipeline and forwarding. It sits beside the EX stage. It consumes the arithmetic ALU's HI/LO write request (`o_we`/`o_hi`/`o_lo`), carries it through MEM and WB stage latches, and commits it to the architectural HI/LO at WB. It returns forwarded `hi`/`lo` values to the ALU, so back-to-back MULT/MULTU/MTHI/MFHI sequences see the newest value without stalling.

## Interface
Parameters:
- none. Data width is fixed at `WORD_BUS` (32 bits).

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ex_we_hi`  in  1  EX-stage write request for HI; ALU `o_we` drives both `ex_we_hi` and `ex_we_lo`
- `ex_we_lo`  in  1  EX-stage write request for LO
- `ex_hi`  in  32  value to write to HI (ALU `o_hi`)
- `ex_lo`  in  32  value to write to LO (ALU `o_lo`)
- `stall_ex`  in  1  EX stage held this cycle
- `stall_mem`  in  1  MEM stage held this cycle
- `flush`  in  1  exception taken in MEM; kill EX and MEM instructions
- `hi`  out  32  forwarded HI to ALU (combinational)
- `lo`  out  32  forwarded LO to ALU (combinational)
- `arch_hi`  out  32  committed HI (registered)
- `arch_lo`  out  32  committed LO (registered)

## Operation
- State:
  - MEM latch: `mem_we_hi`, `mem_we_lo`, `mem_hi`, `mem_lo`.
  - WB latch: `wb_we_hi`, `wb_we_lo`, `wb_hi`, `wb_lo`.
  - Architectural registers: `arch_hi`, `arch_lo`.
- Reset (`rst`=1 at an edge): every latch enable, latch value and architectural register becomes 0. `hi`/`lo` read 0 in the following cycle. Reset overrides stall and flush.
- MEM latch update, by priority:
  1. `flush`: bubble (both enables 0, data 0).
  2. `stall_mem`: hold.
  3. `stall_ex`: bubble.
  4. Otherwise: load the `ex_*` inputs.
- WB latch update, by priority:
  1. `flush` or `stall_mem`: bubble.
  2. Otherwise: load the MEM latch.
- Commit, every edge when not in reset:
  - If `wb_we_hi`, then `arch_hi` <= `wb_hi`.
  - If `wb_we_lo`, then `arch_lo` <= `wb_lo`.
  - Commit is unaffected by stall and flush, because the WB instruction is older than the excepting one.
- Forwarding, independent per register. Shown for HI; LO is identical with `_lo` signals:
  - `hi` = `mem_hi` if `mem_we_hi`.
  - Else `wb_hi` if `wb_we_hi`.
  - Else `arch_hi`.
  - MEM has priority over WB (newest wins).
- The `ex_*` inputs are never forwarded to `hi`/`lo` in the same cycle. This prevents a combinational loop through the ALU.
- `stall_mem`=1 with `stall_ex`=0 is illegal upstream. The block still applies the `stall_mem` rules.
- Writes are full-width replacement. No arithmetic is performed in this block.

## Timing
- A write presented in EX during cycle t is:
  - visible on `hi`/`lo` from cycle t+1, via MEM forwarding;
  - in the WB latch at t+2;
  - on `arch_hi`/`arch_lo` at t+3.
- Each cycle of `stall_mem` delays these points by one cycle; the MEM entry stays forwarded while held.
- `flush` at cycle t: a write in EX or MEM at t never reaches `arch`. A write in WB at t commits at t+1.
- `hi`/`lo` are purely combinational from state. `arch_*` are direct register outputs.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles, release. `hi`, `lo`, `arch_hi`, `arch_lo` are all 0, and stay 0 with no writes.
- MULT forwarding chain: at t, write HI=0xFFFFFFFF, LO=0xFFFFFFFE. At t+1, write HI=0, LO=0x00000006.
  - t+1: `hi`=0xFFFFFFFF.
  - t+2: `hi`=0, `lo`=6 (MEM beats WB).
  - t+3: `arch_hi`=0xFFFFFFFF.
  - t+4: `arch_hi`=0, `arch_lo`=6.
- Split enables (MTHI): write HI=0x12345678 with `ex_we_lo`=0 while `arch_lo`=0xAAAA5555. `lo` stays 0xAAAA5555 throughout; `arch_hi`=0x12345678 at t+3.
- Stall: write 0x11 at t, assert `stall_mem` at t+1 and t+2.
  - MEM holds 0x11 and `hi`=0x11 during t+1..t+3.
  - WB receives bubbles while held.
  - `arch_hi`=0x11 at t+5.
  - `stall_ex` alone at t with `ex_we_hi`=1 inserts a bubble, so no write commits.
- Flush: writes A at t, B at t+1, C at t+2, with `flush`=1 at t+2. A commits (`arch_hi`=A at t+3); B and C never reach `arch_hi`. At t+3, `hi`=A, coming from `arch`.
- Reset mid-flight: write 0x55 at t, `rst`=1 at t+1. At t+2, all outputs are 0, and 0x55 never appears on `arch_hi`.

Source files
------------

// File: rtl/hilo_pipe.sv
// rtl/hilo_pipe.sv - HI/LO register pair with MEM/WB write-back latches and forwarding
// The ex_* inputs are never forwarded in the same cycle so the ALU sees no combinational loop.
module hilo_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_hi,
  input  logic        ex_we_lo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic        flush,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] arch_hi,
  output logic [31:0] arch_lo
);

  logic        r_mem_we_hi;
  logic        r_mem_we_lo;
  logic [31:0] r_mem_hi;
  logic [31:0] r_mem_lo;
  logic        r_wb_we_hi;
  logic        r_wb_we_lo;
  logic [31:0] r_wb_hi;
  logic [31:0] r_wb_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we_hi <= 1'b0;
      r_mem_we_lo <= 1'b0;
      r_mem_hi    <= 32'd0;
      r_mem_lo    <= 32'd0;
      r_wb_we_hi  <= 1'b0;
      r_wb_we_lo  <= 1'b0;
      r_wb_hi     <= 32'd0;
      r_wb_lo     <= 32'd0;
      arch_hi     <= 32'd0;
      arch_lo     <= 32'd0;
    end else begin
      if (flush || (!stall_mem && stall_ex)) begin
        r_mem_we_hi <= 1'b0;
        r_mem_we_lo <= 1'b0;
        r_mem_hi    <= 32'd0;
        r_mem_lo    <= 32'd0;
      end else if (!stall_mem) begin
        r_mem_we_hi <= ex_we_hi;
        r_mem_we_lo <= ex_we_lo;
        r_mem_hi    <= ex_hi;
        r_mem_lo    <= ex_lo;
      end

      if (flush || stall_mem) begin
        r_wb_we_hi <= 1'b0;
        r_wb_we_lo <= 1'b0;
        r_wb_hi    <= 32'd0;
        r_wb_lo    <= 32'd0;
      end else begin
        r_wb_we_hi <= r_mem_we_hi;
        r_wb_we_lo <= r_mem_we_lo;
        r_wb_hi    <= r_mem_hi;
        r_wb_lo    <= r_mem_lo;
      end

      // WB is older than any excepting instruction, so it commits regardless of flush/stall
      if (r_wb_we_hi) arch_hi <= r_wb_hi;
      if (r_wb_we_lo) arch_lo <= r_wb_lo;
    end
  end

  always_comb begin
    if (r_mem_we_hi)     hi = r_mem_hi;
    else if (r_wb_we_hi) hi = r_wb_hi;
    else                 hi = arch_hi;

    if (r_mem_we_lo)     lo = r_mem_lo;
    else if (r_wb_we_lo) lo = r_wb_lo;
    else                 lo = arch_lo;
  end

endmodule
